tree_fanin_node: RTL and testbench



---
 rtl/tree_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/tree_fanin_node.sv | 69 ++++++
 tb/tb_tree_fanin_node.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared definitions for the module-tree fan-in/fan-out nodes.
package tree_pkg;

  localparam int NUM_CHILDREN_DEF = 10;
  localparam int DATA_W_DEF       = 32;

  // Index width for n sources; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(NUM_CHILDREN_DEF);

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ID_W_DEF-1:0]   src;
  } tagged_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the winner on advance.
module rr_arbiter
  import tree_pkg::*;
#(
  parameter int N     = NUM_CHILDREN_DEF,
  parameter int IDX_W = id_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tree_fanin_node.sv
// N-to-1 return-path collector: round-robin merge of child streams into one registered, source-tagged parent stream.
module tree_fanin_node
  import tree_pkg::*;
#(
  parameter int NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ID_W         = id_width(NUM_CHILDREN),
  parameter int CNT_W        = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           parent_valid,
  output logic [DATA_W-1:0]              parent_data,
  output logic [ID_W-1:0]                parent_src,
  input  logic                           parent_ready,
  output logic [CNT_W-1:0]               xfer_count
);

  logic [NUM_CHILDREN-1:0] grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    load_en;
  logic                    xfer;
  logic [DATA_W-1:0]       sel_data;

  // Output slot may refill in the same cycle it drains.
  assign load_en     = !parent_valid || parent_ready;
  assign child_ready = rst_n ? (grant & {NUM_CHILDREN{load_en}}) : '0;
  assign xfer        = |child_ready;

  rr_arbiter #(
    .N     (NUM_CHILDREN),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (child_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot AND-OR mux keeps the data select free of variable part-selects.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (grant[i]) sel_data = sel_data | child_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parent_valid <= 1'b0;
      parent_data  <= '0;
      parent_src   <= '0;
      xfer_count   <= '0;
    end else begin
      if (load_en) parent_valid <= xfer;
      if (xfer) begin
        parent_data <= sel_data;
        parent_src  <= grant_idx;
        xfer_count  <= xfer_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tree_fanin_node.sv
// Bench for tree_fanin_node: reference arbitration model plus beat scoreboard, and scenario tasks.
module tb_tree_fanin_node;
  import tree_pkg::*;

  localparam int N  = NUM_CHILDREN_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int IW = ID_W_DEF;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      child_valid;
  logic [N*DW-1:0]   child_data;
  logic [N-1:0]      child_ready;
  logic              parent_valid;
  logic [DW-1:0]     parent_data;
  logic [IW-1:0]     parent_src;
  logic              parent_ready;
  logic [CW-1:0]     xfer_count;

  int checks = 0;
  int errors = 0;

  tree_fanin_node #(.NUM_CHILDREN(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .child_valid  (child_valid),
    .child_data   (child_data),
    .child_ready  (child_ready),
    .parent_valid (parent_valid),
    .parent_data  (parent_data),
    .parent_src   (parent_src),
    .parent_ready (parent_ready),
    .xfer_count   (xfer_count)
  );

  always #5 clk = ~clk;

  // Reference model, evaluated on the falling edge while inputs are stable.
  bit           mon_en = 1'b0;
  int           ptr_m = 0;
  bit           pv_m = 1'b0;
  int           cnt_m = 0;
  int           g, j;
  bit           ld;
  logic [N-1:0] exp_rdy;
  tagged_beat_t sb[$];
  tagged_beat_t b;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        checks++;
        if (child_ready !== '0) begin
          errors++;
          $display("FAIL rst_ready: got %b expected 0", child_ready);
        end
        ptr_m = 0; pv_m = 1'b0; cnt_m = 0;
        sb.delete();
      end else begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          j = (ptr_m + k) % N;
          if (g < 0 && child_valid[j]) g = j;
        end
        ld = !pv_m || parent_ready;
        exp_rdy = '0;
        if (g >= 0 && ld) exp_rdy[g] = 1'b1;
        checks++;
        if (child_ready !== exp_rdy) begin
          errors++;
          $display("FAIL child_ready: got %b expected %b", child_ready, exp_rdy);
        end
        checks++;
        if (parent_valid !== pv_m) begin
          errors++;
          $display("FAIL parent_valid: got %b expected %b", parent_valid, pv_m);
        end
        checks++;
        if (xfer_count !== CW'(cnt_m)) begin
          errors++;
          $display("FAIL xfer_count: got %0d expected %0d", xfer_count, cnt_m);
        end
        if (pv_m && parent_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: beat delivered with no expected entry");
          end else begin
            b = sb.pop_front();
            if (parent_data !== b.data || parent_src !== b.src) begin
              errors++;
              $display("FAIL beat: got data %h src %0d expected data %h src %0d",
                       parent_data, parent_src, b.data, b.src);
            end
          end
        end
        if (exp_rdy != '0) begin
          b.data = child_data[g*DW +: DW];
          b.src  = IW'(g);
          sb.push_back(b);
          ptr_m = (g + 1) % N;
          cnt_m++;
        end
        if (ld) pv_m = (exp_rdy != '0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    child_valid  = '0;
    parent_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    child_valid  = '1;
    parent_ready = 1'b1;
    cyc();
    mon_en = 1'b1;
    cyc();
    checks++;
    if (parent_valid !== 1'b0 || parent_data !== '0 || parent_src !== '0 || xfer_count !== '0) begin
      errors++;
      $display("FAIL reset_state: pv %b data %h src %0d cnt %0d expected all 0",
               parent_valid, parent_data, parent_src, xfer_count);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (parent_valid !== 1'b1 || parent_src !== IW'(0) || parent_data !== DW'(32'h100)) begin
      errors++;
      $display("FAIL first_beat: pv %b src %0d data %h expected 1 0 100",
               parent_valid, parent_src, parent_data);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    cyc();
    rst_n        = 1'b1;
    child_valid  = '1;
    parent_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if (parent_valid !== 1'b1 || parent_src !== IW'(k % N) ||
          parent_data !== DW'(32'h100 + k % N) || xfer_count !== CW'(k + 1)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: pv %b src %0d data %h cnt %0d expected src %0d cnt %0d",
                 k, parent_valid, parent_src, parent_data, xfer_count, k % N, k + 1);
      end
    end
    drain();
  endtask

  task automatic test_single();
    child_valid = '0;
    child_valid[7] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (parent_valid !== 1'b1 || parent_src !== IW'(7) || parent_data !== DW'(32'h107)) begin
        errors++;
        $display("FAIL single[%0d]: pv %b src %0d data %h expected 1 7 107",
                 k, parent_valid, parent_src, parent_data);
      end
    end
    drain();
  endtask

  task automatic test_stall();
    child_valid  = '1;
    parent_ready = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (parent_valid !== 1'b1 || parent_src !== IW'(8) || parent_data !== DW'(32'h108)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pv %b src %0d data %h expected 1 8 108",
                 k, parent_valid, parent_src, parent_data);
      end
    end
    parent_ready = 1'b1;
    cyc();
    checks++;
    if (parent_src !== IW'(9) || parent_data !== DW'(32'h109)) begin
      errors++;
      $display("FAIL stall_next: src %0d data %h expected 9 109", parent_src, parent_data);
    end
    cyc();
    checks++;
    if (parent_src !== IW'(0)) begin
      errors++;
      $display("FAIL stall_wrap: src %0d expected 0", parent_src);
    end
    drain();
  endtask

  task automatic test_wrap();
    child_valid = '0;
    child_valid[8] = 1'b1;
    cyc();
    child_valid = '0;
    child_valid[3] = 1'b1;
    child_valid[9] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (parent_src !== IW'((k % 2) ? 3 : 9)) begin
        errors++;
        $display("FAIL wrap[%0d]: src %0d expected %0d", k, parent_src, (k % 2) ? 3 : 9);
      end
    end
    drain();
  endtask

  task automatic test_reset_stall();
    child_valid  = '1;
    parent_ready = 1'b0;
    cyc();
    cyc();
    checks++;
    if (parent_valid !== 1'b1) begin
      errors++;
      $display("FAIL rs_held: pv %b expected 1", parent_valid);
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if (parent_valid !== 1'b0 || xfer_count !== '0) begin
      errors++;
      $display("FAIL rs_pulse: pv %b cnt %0d expected 0 0", parent_valid, xfer_count);
    end
    rst_n        = 1'b1;
    child_valid  = '0;
    parent_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (parent_valid !== 1'b0 || xfer_count !== '0) begin
        errors++;
        $display("FAIL rs_discard[%0d]: pv %b cnt %0d expected 0 0", k, parent_valid, xfer_count);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) child_data[i*DW +: DW] = DW'(32'h100 + i);
    child_valid  = '0;
    parent_ready = 1'b1;
    rst_n        = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_wrap();
    test_reset_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
